motor_command_shaper: RTL and testbench

- Upstream stage of the H-bridge PWM block; feeds its motor1_sign/motor1_upperlimit and motor2_sign/motor2_upperlimit inputs.
- Converts two signed 16-bit control-effort words from the balance loop into a sign bit and a 7-bit duty magnitude per motor.
- Applies arithmetic scaling, saturation, deadband and slew-rate limiting.
- A command watchdog ramps both motors to zero if the loop stops issuing commands.

---
 rtl/motor_command_shaper_if.sv | 21 ++
 rtl/motor_command_shaper.sv | 123 ++++++++++++
 tb/tb_motor_command_shaper.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/motor_command_shaper_if.sv
// Command/duty bundle between the balance loop, the shaper and the H-bridge PWM stage.
interface motor_command_shaper_if;
  logic               cmd_valid;
  logic signed [15:0] motor1_effort;
  logic signed [15:0] motor2_effort;
  logic               motor1_sign;
  logic [6:0]         motor1_upperlimit;
  logic               motor2_sign;
  logic [6:0]         motor2_upperlimit;
  logic               fault;

  modport master (
    output cmd_valid, motor1_effort, motor2_effort,
    input  motor1_sign, motor1_upperlimit, motor2_sign, motor2_upperlimit, fault
  );

  modport slave (
    input  cmd_valid, motor1_effort, motor2_effort,
    output motor1_sign, motor1_upperlimit, motor2_sign, motor2_upperlimit, fault
  );
endinterface

// File: rtl/motor_command_shaper.sv
// Shapes signed effort words into sign + duty magnitude per motor with scaling,
// saturation, deadband, slew limiting and a command watchdog.
module motor_command_shaper #(
  parameter int EFFORT_SHIFT = 4,
  parameter int MAX_DUTY     = 100,
  parameter int DEADBAND     = 3,
  parameter int SLEW_STEP    = 2,
  parameter int SLEW_DIV     = 1000,
  parameter int WDOG_CYCLES  = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  motor_command_shaper_if.slave bus
);
  localparam int PW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(SLEW_DIV - 1);
  localparam logic [WW-1:0]       WDOG_MAX   = WW'(WDOG_CYCLES);
  localparam logic signed [8:0]   STEP9      = 9'(SLEW_STEP);
  localparam logic signed [7:0]   STEP8      = 8'(SLEW_STEP);

  logic signed [7:0] tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic signed [7:0] cur1_q, cur1_d, cur2_q, cur2_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              fault_q, fault_d;
  logic              sign1_q, sign1_d, sign2_q, sign2_d;
  logic [6:0]        ul1_q, ul1_d, ul2_q, ul2_d;
  logic              tick;

  // Magnitude is taken in 17 bits so the most negative effort cannot overflow.
  function automatic logic signed [7:0] shape(input logic signed [15:0] effort);
    logic signed [15:0] s;
    logic [16:0]        m;
    logic [6:0]         mag;
    s = effort >>> EFFORT_SHIFT;
    m = s[15] ? -{s[15], s} : {s[15], s};
    if (m > 17'(MAX_DUTY)) m = 17'(MAX_DUTY);
    mag = m[6:0];
    if (mag < 7'(DEADBAND)) mag = '0;
    return s[15] ? -{1'b0, mag} : {1'b0, mag};
  endfunction

  function automatic logic signed [7:0] slew(input logic signed [7:0] tgt,
                                             input logic signed [7:0] cur);
    logic signed [8:0] d;
    d = {tgt[7], tgt} - {cur[7], cur};
    if (d > STEP9)       return cur + STEP8;
    else if (d < -STEP9) return cur - STEP8;
    else                 return tgt;
  endfunction

  function automatic logic [6:0] magnitude(input logic signed [7:0] v);
    return v[7] ? 7'(-v) : v[6:0];
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;

    wd_d    = wd_q;
    fault_d = fault_q;
    tgt1_d  = tgt1_q;
    tgt2_d  = tgt2_q;
    if (bus.cmd_valid) begin
      wd_d    = '0;
      fault_d = 1'b0;
      tgt1_d  = shape(bus.motor1_effort);
      tgt2_d  = shape(bus.motor2_effort);
    end else begin
      if (wd_q != WDOG_MAX) wd_d = wd_q + 1'b1;
      // Targets stay pinned at zero for as long as the counter sits saturated.
      if (wd_d == WDOG_MAX) begin
        fault_d = 1'b1;
        tgt1_d  = '0;
        tgt2_d  = '0;
      end
    end

    // Slew uses the target registered before this cycle's command, if any.
    cur1_d  = tick ? slew(tgt1_q, cur1_q) : cur1_q;
    cur2_d  = tick ? slew(tgt2_q, cur2_q) : cur2_q;

    ul1_d   = magnitude(cur1_q);
    ul2_d   = magnitude(cur2_q);
    sign1_d = (cur1_q == '0) ? sign1_q : ~cur1_q[7];
    sign2_d = (cur2_q == '0) ? sign2_q : ~cur2_q[7];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt1_q  <= '0;
      tgt2_q  <= '0;
      cur1_q  <= '0;
      cur2_q  <= '0;
      presc_q <= '0;
      wd_q    <= '0;
      fault_q <= 1'b0;
      sign1_q <= 1'b1;
      sign2_q <= 1'b1;
      ul1_q   <= '0;
      ul2_q   <= '0;
    end else begin
      tgt1_q  <= tgt1_d;
      tgt2_q  <= tgt2_d;
      cur1_q  <= cur1_d;
      cur2_q  <= cur2_d;
      presc_q <= presc_d;
      wd_q    <= wd_d;
      fault_q <= fault_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      ul1_q   <= ul1_d;
      ul2_q   <= ul2_d;
    end
  end

  assign bus.motor1_sign       = sign1_q;
  assign bus.motor1_upperlimit = ul1_q;
  assign bus.motor2_sign       = sign2_q;
  assign bus.motor2_upperlimit = ul2_q;
  assign bus.fault             = fault_q;
endmodule

// File: tb/tb_motor_command_shaper.sv
// Bench for motor_command_shaper: integer reference model, table vectors, directed corners, random commands.
module tb_motor_command_shaper;
  localparam int SLEW_DIV = 4;
  localparam int WDOG     = 60;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  motor_command_shaper_if bus();

  motor_command_shaper #(
    .EFFORT_SHIFT(4), .MAX_DUTY(100), .DEADBAND(3), .SLEW_STEP(2),
    .SLEW_DIV(SLEW_DIV), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Reference model in plain integers: effort/16 rounded toward -inf, clamp, deadband.
  int m_tgt[2]  = '{0, 0};
  int m_cur[2]  = '{0, 0};
  int m_mag[2]  = '{0, 0};
  int m_sign[2] = '{1, 1};
  int m_presc = 0, m_wd = 0, m_fault = 0;
  int m_eff[2];
  int m_diff;
  bit m_tick;

  function automatic int shaped(input int e);
    int s, m;
    s = (e >= 0) ? e / 16 : -((-e + 15) / 16);
    m = (s < 0) ? -s : s;
    if (m > 100) m = 100;
    if (m < 3) m = 0;
    return (s < 0) ? -m : m;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_tgt = '{0, 0}; m_cur = '{0, 0}; m_mag = '{0, 0}; m_sign = '{1, 1};
      m_presc = 0; m_wd = 0; m_fault = 0;
    end else begin
      m_tick = (m_presc == SLEW_DIV - 1);
      m_eff[0] = bus.motor1_effort;
      m_eff[1] = bus.motor2_effort;
      for (int i = 0; i < 2; i++) begin
        m_mag[i] = (m_cur[i] < 0) ? -m_cur[i] : m_cur[i];
        if (m_cur[i] > 0) m_sign[i] = 1;
        else if (m_cur[i] < 0) m_sign[i] = 0;
        if (m_tick) begin
          m_diff = m_tgt[i] - m_cur[i];
          if (m_diff >= -2 && m_diff <= 2) m_cur[i] = m_tgt[i];
          else m_cur[i] = m_cur[i] + ((m_diff > 0) ? 2 : -2);
        end
      end
      m_presc = m_tick ? 0 : m_presc + 1;
      if (bus.cmd_valid) begin
        m_wd = 0; m_fault = 0;
        m_tgt[0] = shaped(m_eff[0]);
        m_tgt[1] = shaped(m_eff[1]);
      end else begin
        if (m_wd < WDOG) m_wd++;
        if (m_wd == WDOG) begin m_fault = 1; m_tgt = '{0, 0}; end
      end
    end
  end

  int n_pass = 0, n_total = 0;
  int ef1 = 0, ef2 = 0, cyc = 0;
  bit pend_cmd = 0, keepalive = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic cmd(input int e1, input int e2);
    ef1 = e1; ef2 = e2; pend_cmd = 1;
  endtask

  // One cycle: compare against the model at the falling edge, then drive the next inputs.
  task automatic step();
    @(negedge clk);
    chk("model_m1", {bus.motor1_sign, bus.motor1_upperlimit}, m_sign[0] * 128 + m_mag[0]);
    chk("model_m2", {bus.motor2_sign, bus.motor2_upperlimit}, m_sign[1] * 128 + m_mag[1]);
    chk("model_fault", bus.fault, m_fault);
    bus.cmd_valid     = pend_cmd || (keepalive && (cyc % 30 == 29));
    bus.motor1_effort = 16'(ef1);
    bus.motor2_effort = 16'(ef2);
    pend_cmd = 0;
    cyc++;
  endtask

  typedef struct { int e1; int e2; int mag1; int sgn1; int mag2; int sgn2; } vec_t;
  vec_t vecs[6];
  int rev_mag[10] = '{8, 6, 4, 2, 0, 2, 4, 6, 8, 10};
  int rev_sgn[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int prev, chg2, c, pick, rate;
  int extremes[4] = '{32767, -32768, 1615, -1616};

  initial begin
    vecs[0] = '{32767, -32768, 100, 1, 100, 0};
    vecs[1] = '{47,     48,      0, 1,   3, 1};
    vecs[2] = '{-47,   -32,      3, 0,   0, 1};
    vecs[3] = '{15,     1600,    0, 0, 100, 1};
    vecs[4] = '{1615,  -1616,  100, 1, 100, 0};
    vecs[5] = '{800,   -800,    50, 1,  50, 0};

    bus.cmd_valid = 0; bus.motor1_effort = '0; bus.motor2_effort = '0;
    reset = 0;
    repeat (3) step();
    chk("rst_sign1", bus.motor1_sign, 1);
    chk("rst_ul1", bus.motor1_upperlimit, 0);
    chk("rst_sign2", bus.motor2_sign, 1);
    chk("rst_ul2", bus.motor2_upperlimit, 0);
    chk("rst_fault", bus.fault, 0);
    reset = 1;

    // Ramp to +50 / -50, one step of 2 per tick.
    keepalive = 1;
    cmd(800, -800);
    prev = 0; chg2 = 0;
    for (int i = 0; i < 400 && bus.motor1_upperlimit != 7'd50; i++) begin
      c = bus.motor2_upperlimit;
      step();
      if (bus.motor2_upperlimit != 7'(c)) chg2++;
      if (bus.motor1_upperlimit != 7'(prev)) begin
        chk("ramp1_step", bus.motor1_upperlimit, prev + 2);
        chk("ramp1_sign", bus.motor1_sign, 1);
        prev = bus.motor1_upperlimit;
      end
    end
    chk("ramp1_final", bus.motor1_upperlimit, 50);
    chk("ramp2_final", bus.motor2_upperlimit, 50);
    chk("ramp2_sign", bus.motor2_sign, 0);
    chk("ramp2_ticks", chg2, 25);

    // Saturation / deadband table.
    for (int v = 0; v < 6; v++) begin
      cmd(vecs[v].e1, vecs[v].e2);
      repeat (520) step();
      chk("tbl_mag1", bus.motor1_upperlimit, vecs[v].mag1);
      chk("tbl_sign1", bus.motor1_sign, vecs[v].sgn1);
      chk("tbl_mag2", bus.motor2_upperlimit, vecs[v].mag2);
      chk("tbl_sign2", bus.motor2_sign, vecs[v].sgn2);
    end

    // Reversal +10 -> -10 passes through 0 with sign held.
    cmd(160, -160);
    repeat (200) step();
    chk("rev_start", bus.motor1_upperlimit, 10);
    cmd(-160, 160);
    prev = 10;
    for (int k = 0; k < 10; k++) begin
      c = 0;
      while (bus.motor1_upperlimit == 7'(prev) && c < 20) begin step(); c++; end
      chk("rev_mag", bus.motor1_upperlimit, rev_mag[k]);
      chk("rev_sign", bus.motor1_sign, rev_sgn[k]);
      prev = bus.motor1_upperlimit;
    end

    // Watchdog expiry and recovery.
    cmd(800, 800);
    repeat (200) step();
    chk("wd_pre", bus.motor1_upperlimit, 50);
    keepalive = 0;
    cmd(800, 800);
    repeat (61) step();
    chk("wd_not_yet", bus.fault, 0);
    step();
    chk("wd_fault", bus.fault, 1);
    c = 0;
    while ((bus.motor1_upperlimit != 0 || bus.motor2_upperlimit != 0) && c < 300) begin step(); c++; end
    chk("wd_ramp1", bus.motor1_upperlimit, 0);
    chk("wd_ramp2", bus.motor2_upperlimit, 0);
    chk("wd_hold", bus.fault, 1);
    cmd(320, 320);
    step(); step();
    chk("wd_clear", bus.fault, 0);
    keepalive = 1;
    repeat (200) step();
    chk("wd_recover", bus.motor1_upperlimit, 20);
    chk("wd_recover_sign", bus.motor1_sign, 1);

    // Command landing on the expiry cycle wins.
    keepalive = 0;
    cmd(320, 320);
    repeat (60) step();
    pend_cmd = 1;
    step(); step();
    chk("expiry_cmd_wins", bus.fault, 0);

    // Asynchronous reset mid-ramp.
    keepalive = 1;
    cmd(320, -320);
    repeat (200) step();
    cmd(800, -800);
    c = 0;
    while (bus.motor1_upperlimit != 7'd40 && c < 200) begin step(); c++; end
    chk("mid_ul1", bus.motor1_upperlimit, 40);
    chk("mid_sign2", bus.motor2_sign, 0);
    #2 reset = 0;
    #1;
    chk("arst_ul1", bus.motor1_upperlimit, 0);
    chk("arst_sign1", bus.motor1_sign, 1);
    chk("arst_ul2", bus.motor2_upperlimit, 0);
    chk("arst_sign2", bus.motor2_sign, 1);
    chk("arst_fault", bus.fault, 0);
    step(); step();
    reset = 1;

    // Random commands, alternating busy and sparse phases so the watchdog also fires.
    keepalive = 0;
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 2 == 1) ? 99 : 15;
      if ($urandom_range(0, rate) == 0) begin
        pick = $urandom_range(0, 3);
        case (pick)
          0:       begin ef1 = $signed(16'($urandom)); ef2 = $signed(16'($urandom)); end
          1:       begin ef1 = $urandom_range(0, 200) - 100; ef2 = $urandom_range(0, 200) - 100; end
          2:       begin ef1 = extremes[$urandom_range(0, 3)]; ef2 = extremes[$urandom_range(0, 3)]; end
          default: begin ef1 = $urandom_range(0, 3400) - 1700; ef2 = $urandom_range(0, 3400) - 1700; end
        endcase
        pend_cmd = 1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
